// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file write port: merges LSU/ALU results,
// buffers them while the port is held, and answers forwarding lookups on pending writes.
module regfile_wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [4:0]                 alu_rd,
  input  logic [XLEN-1:0]            alu_data,
  input  logic                       lsu_valid,
  output logic                       lsu_ready,
  input  logic [4:0]                 lsu_rd,
  input  logic [XLEN-1:0]            lsu_data,
  input  logic                       wb_hold,
  output logic [4:0]                 rf_rd_addr,
  output logic [XLEN-1:0]            rf_rd_data,
  output logic                       rf_rd_we,
  input  logic [4:0]                 q1_addr,
  output logic                       q1_hit,
  output logic [XLEN-1:0]            q1_data,
  input  logic [4:0]                 q2_addr,
  output logic                       q2_hit,
  output logic [XLEN-1:0]            q2_data,
  output logic [$clog2(DEPTH):0]     pending
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]      fifo_rd   [DEPTH];
  logic [XLEN-1:0] fifo_data [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;

  logic            not_full, empty;
  logic            lsu_acc, alu_acc;
  logic [4:0]      in_rd;
  logic [XLEN-1:0] in_data;
  logic            w_valid, do_pop, do_bypass, do_push;

  assign not_full  = (count < CW'(DEPTH));
  assign empty     = (count == '0);
  assign lsu_ready = not_full;
  assign alu_ready = not_full & ~lsu_valid;
  assign lsu_acc   = lsu_valid & lsu_ready;
  assign alu_acc   = alu_valid & alu_ready;
  assign in_rd     = lsu_acc ? lsu_rd : alu_rd;
  assign in_data   = lsu_acc ? lsu_data : alu_data;

  // Results aimed at x0 complete the handshake but never enter the write stream.
  assign w_valid   = (lsu_acc | alu_acc) && (in_rd != 5'd0);
  assign do_pop    = ~wb_hold & ~empty;
  assign do_bypass = ~wb_hold & empty & w_valid;
  assign do_push   = w_valid & ~do_bypass;
  assign pending   = count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      rf_rd_we   <= 1'b0;
      rf_rd_addr <= '0;
      rf_rd_data <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count + CW'(do_push) - CW'(do_pop);
      rf_rd_we <= do_pop | do_bypass;
      if (do_pop) begin
        rf_rd_addr <= fifo_rd[rd_ptr];
        rf_rd_data <= fifo_data[rd_ptr];
      end else if (do_bypass) begin
        rf_rd_addr <= in_rd;
        rf_rd_data <= in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      fifo_rd[wr_ptr]   <= in_rd;
      fifo_data[wr_ptr] <= in_data;
    end
  end

  // Scan oldest to youngest so the last match (youngest write) wins.
  function automatic logic [XLEN:0] lookup(input logic [4:0] a);
    logic            hit;
    logic [XLEN-1:0] d;
    logic [AW-1:0]   idx;
    hit = 1'b0;
    d   = '0;
    if (rf_rd_we && rf_rd_addr == a) begin
      hit = 1'b1;
      d   = rf_rd_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + AW'(i);
      if (CW'(i) < count && fifo_rd[idx] == a) begin
        hit = 1'b1;
        d   = fifo_data[idx];
      end
    end
    if (a == 5'd0) begin
      hit = 1'b0;
      d   = '0;
    end
    return {hit, d};
  endfunction

  always_comb begin
    {q1_hit, q1_data} = lookup(q1_addr);
    {q2_hit, q2_data} = lookup(q2_addr);
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: queue-level reference model, directed
// scenarios followed by randomized traffic with holds, x0 writes and resets.
module tb_regfile_wb_arbiter;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            alu_valid = 1'b0, lsu_valid = 1'b0, wb_hold = 1'b0;
  logic            alu_ready, lsu_ready;
  logic [4:0]      alu_rd = '0, lsu_rd = '0, q1_addr = '0, q2_addr = '0;
  logic [XLEN-1:0] alu_data = '0, lsu_data = '0;
  logic [4:0]      rf_rd_addr;
  logic [XLEN-1:0] rf_rd_data, q1_data, q2_data;
  logic            rf_rd_we, q1_hit, q2_hit;
  logic [CW-1:0]   pending;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wr_t;

  wr_t  m_fifo[$];
  wr_t  exp_q[$];
  wr_t  m_out;
  logic m_out_we = 1'b0;
  logic acc_valid;
  wr_t  acc_w;
  logic cyc_hold;
  int   checks = 0;
  int   errors = 0;

  regfile_wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .wb_hold(wb_hold),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data), .rf_rd_we(rf_rd_we),
    .q1_addr(q1_addr), .q1_hit(q1_hit), .q1_data(q1_data),
    .q2_addr(q2_addr), .q2_hit(q2_hit), .q2_data(q2_data),
    .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic compareValue(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Youngest pending write to an address; the output register is the oldest candidate.
  function automatic logic [XLEN:0] modelLookup(input logic [4:0] a);
    logic            hit = 1'b0;
    logic [XLEN-1:0] d = '0;
    if (a != 5'd0) begin
      if (m_out_we && m_out.rd == a) begin hit = 1'b1; d = m_out.data; end
      foreach (m_fifo[i]) if (m_fifo[i].rd == a) begin hit = 1'b1; d = m_fifo[i].data; end
    end
    return {hit, d};
  endfunction

  task automatic checkOutput();
    logic            exp_rdy;
    logic [XLEN:0]   f1, f2;
    exp_rdy = (m_fifo.size() < DEPTH);
    f1 = modelLookup(q1_addr);
    f2 = modelLookup(q2_addr);
    compareValue("lsu_ready", lsu_ready, exp_rdy);
    compareValue("alu_ready", alu_ready, exp_rdy && !lsu_valid);
    compareValue("pending", pending, m_fifo.size());
    compareValue("rf_rd_we", rf_rd_we, m_out_we);
    compareValue("q1_hit", q1_hit, f1[XLEN]);
    compareValue("q1_data", q1_data, f1[XLEN-1:0]);
    compareValue("q2_hit", q2_hit, f2[XLEN]);
    compareValue("q2_data", q2_data, f2[XLEN-1:0]);
    acc_valid = 1'b0;
    if (lsu_valid && exp_rdy) begin
      acc_w = '{lsu_rd, lsu_data};
      acc_valid = (lsu_rd != 5'd0);
    end else if (alu_valid && exp_rdy) begin
      acc_w = '{alu_rd, alu_data};
      acc_valid = (alu_rd != 5'd0);
    end
    if (acc_valid) exp_q.push_back(acc_w);
    cyc_hold = wb_hold;
  endtask

  task automatic updateModel();
    if (!cyc_hold) begin
      if (m_fifo.size() > 0) begin
        m_out    = m_fifo.pop_front();
        m_out_we = 1'b1;
        if (acc_valid) m_fifo.push_back(acc_w);
      end else if (acc_valid) begin
        m_out    = acc_w;
        m_out_we = 1'b1;
      end else begin
        m_out_we = 1'b0;
      end
    end else begin
      m_out_we = 1'b0;
      if (acc_valid) m_fifo.push_back(acc_w);
    end
  endtask

  task automatic applyStimulus(input logic lv, input logic [4:0] lrd, input logic [XLEN-1:0] ld,
                               input logic av, input logic [4:0] ard, input logic [XLEN-1:0] ad,
                               input logic hold, input logic [4:0] qa1, input logic [4:0] qa2);
    @(negedge clk);
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    wb_hold = hold; q1_addr = qa1; q2_addr = qa2;
    #1;
    checkOutput();
    @(posedge clk);
    updateModel();
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    lsu_valid = 1'b0; alu_valid = 1'b0; wb_hold = 1'b0;
    @(posedge clk);
    m_fifo.delete();
    exp_q.delete();
    m_out_we = 1'b0;
    m_out    = '{5'd0, '0};
    @(negedge clk);
    rst_n = 1'b1;
    compareValue("reset_rf_rd_addr", rf_rd_addr, 0);
    compareValue("reset_rf_rd_data", rf_rd_data, 0);
    compareValue("reset_rf_rd_we", rf_rd_we, 0);
    compareValue("reset_pending", pending, 0);
  endtask

  // Write monitor: every register file write must match the oldest expected write.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rf_rd_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_write: got addr %0d data 0x%0h, expected no write", rf_rd_addr, rf_rd_data);
        end else begin
          e = exp_q.pop_front();
          compareValue("wr_addr", rf_rd_addr, e.rd);
          compareValue("wr_data", rf_rd_data, e.data);
        end
      end
    end
  end

  initial begin
    doReset();

    // T1: single ALU write, one-cycle latency.
    applyStimulus(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 5, 0);
    #2;
    compareValue("t1_we", rf_rd_we, 1);
    compareValue("t1_addr", rf_rd_addr, 5);
    compareValue("t1_data", rf_rd_data, 32'hDEADBEEF);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 5, 0);

    // T2: LSU wins the simultaneous offer, ALU follows.
    applyStimulus(1, 3, 32'h11, 1, 4, 32'h22, 0, 3, 4);
    applyStimulus(0, 0, 0, 1, 4, 32'h22, 0, 3, 4);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 3, 4);

    // T3: fill under hold, then a refused offer, then drain.
    for (int i = 1; i <= 4; i++) applyStimulus(1, 5'(i), 32'(i * 16), 0, 0, 0, 1, 2, 4);
    applyStimulus(1, 9, 32'h99, 1, 10, 32'hAA, 1, 1, 9);
    compareValue("t3_pending", pending, 4);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 4);

    // T4: x0 result is accepted and dropped.
    applyStimulus(0, 0, 0, 1, 0, 32'hFFFF, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // T5: youngest of two x7 writes forwards.
    applyStimulus(0, 0, 0, 1, 7, 32'h1, 1, 7, 8);
    applyStimulus(0, 0, 0, 1, 7, 32'h2, 1, 7, 8);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 7, 8);
    #2;
    compareValue("t5_q1_data", q1_data, 2);
    compareValue("t5_q2_hit", q2_hit, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 7, 8);

    // T6: reset with entries pending drops them all.
    for (int i = 1; i <= 3; i++) applyStimulus(1, 5'(10 + i), 32'(i), 0, 0, 0, 1, 11, 12);
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 11, 12);

    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(199) == 0) doReset();
      applyStimulus($urandom_range(2) == 0, 5'($urandom_range(7)), $urandom,
                    $urandom_range(1) == 0, 5'($urandom_range(7)), $urandom,
                    $urandom_range(9) < 4, 5'($urandom_range(7)), 5'($urandom_range(7)));
    end

    for (int i = 0; i < DEPTH + 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 2);
    @(negedge clk);
    compareValue("drain_expected_writes_left", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
